sequential_divider: RTL and testbench
=====================================

Name: sequential_divider

Overview:
- Iterative restoring divider; the inverse operation of the team's 4x4 array multiplier.
- Divides a 2N-bit unsigned dividend by an N-bit unsigned divisor, producing a 2N-bit quotient and an N-bit remainder.
- One quotient bit per clock, using a start/busy/done handshake.
- Used alongside the multiplier in the arithmetic datapath; the multiply-then-divide round-trip is the primary check.

Parameters:
N, 4, divisor/remainder width; dividend and quotient are 2N bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
dividend  input  2N  unsigned dividend, captured on accepted start
divisor  input  N  unsigned divisor, captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: results valid
quotient  output  2N  unsigned quotient, held until next accepted start
remainder  output  N  unsigned remainder, held until next accepted start
div_by_zero  output  1  high with done when captured divisor was 0; held with results

Behaviour:
- Reset: asynchronous, active-low, on rst_n falling (no clock needed). Forces state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- Reset mid-operation abandons the operation. No done is produced.
- States and transitions:
  - IDLE: start=1 at edge -> capture operands, clear quotient/remainder/div_by_zero.
    - Divisor==0 -> go to DONE.
    - Otherwise -> go to RUN with counter=0 and busy=1.
  - RUN: each edge performs one restoring step.
    - Partial remainder P is (N+1) bits, initialised to 0. Shift register D holds the dividend.
    - Per step: P' = {P[N-1:0], D[2N-1]}, then D shifts left.
    - If P' >= {1'b0,divisor}: P = P' - divisor and shift in quotient bit 1. Else P = P' and shift in 0.
    - Counter increments. On the step where counter reaches 2N-1 -> go to DONE.
  - DONE: done=1, busy=0, results valid for exactly one cycle, then go to IDLE.
    - start=1 during DONE is accepted as in IDLE (back-to-back ops).
    - done stays a one-cycle pulse; outputs update on the accepted edge.
- Latency, with start sampled at edge k:
  - Normal: done high in the cycle after edge k+2N, i.e. 2N cycles (8 for N=4).
  - busy is high from edge k to edge k+2N.
  - Divisor 0: done high after edge k+1. busy never asserts.
- Divide by zero: quotient={2N{1'b1}}, remainder=dividend[N-1:0], div_by_zero=1.
- start while busy=1 is ignored. Operand inputs are don't-care except at the accepting edge.
- Operand changes after capture do not affect the running operation.
- Result invariants:
  - dividend == quotient*divisor + remainder, and remainder < divisor, for all divisor != 0.
  - The quotient cannot overflow, because it is 2N bits wide.
- quotient and remainder are registered outputs. They change only at reset, at an accepted start (cleared), or during RUN/DONE; they are final when done=1.

Test Plan:
- Reset, then start with dividend=200, divisor=7 -> done exactly 8 cycles after the start edge; quotient=28, remainder=4, div_by_zero=0; busy high for 8 cycles.
- dividend=255, divisor=1 -> quotient=255, remainder=0. dividend=5, divisor=9 -> quotient=0, remainder=5. dividend=255, divisor=15 -> quotient=17, remainder=0.
- dividend=13, divisor=0 -> done 1 cycle after start; quotient=8'hFF, remainder=4'hD, div_by_zero=1; busy stays 0.
- Start 200/7, pulse start again with 99/3 at cycle 3 -> second request ignored; result 28 r 4. Then start 99/3 during the done cycle -> accepted; done 8 cycles later with 33 r 0.
- Drop rst_n asynchronously mid-RUN (cycle 4) -> all outputs 0 immediately; no done pulse. After release, 144/12 -> 12 r 0.
- Exhaustive: all 256x16 operand pairs, each result checked against the multiplier (quotient*divisor + remainder == dividend, remainder < divisor). Divisor-0 cases checked against the divide-by-zero rule.

Source files
------------

// File: rtl/sequential_divider.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// A start/busy/done handshake; a zero divisor skips the iterations and flags div_by_zero.
module sequential_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, RUN, DZ, DONE} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_d;
  logic [2*N-1:0] r_q;
  logic [N-1:0]   r_p;
  logic [N-1:0]   r_dvs;
  logic           r_busy;
  logic           r_done;
  logic           r_dz;

  logic [N:0]     w_pshift;
  logic           w_ge;
  logic [N-1:0]   w_pnext;

  // A restored partial remainder is always below the divisor, so N bits hold it
  // and the subtraction can be done modulo 2^N.
  assign w_pshift = {r_p, r_d[2*N-1]};
  assign w_ge     = (w_pshift >= {1'b0, r_dvs});
  assign w_pnext  = w_ge ? (w_pshift[N-1:0] - r_dvs) : w_pshift[N-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_d     <= '0;
      r_q     <= '0;
      r_p     <= '0;
      r_dvs   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_d   <= dividend;
            r_dvs <= divisor;
            r_cnt <= '0;
            if (divisor == '0) begin
              r_q     <= '1;
              r_p     <= dividend[N-1:0];
              r_dz    <= 1'b1;
              r_state <= DZ;
            end else begin
              r_q     <= '0;
              r_p     <= '0;
              r_dz    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= RUN;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_d   <= {r_d[2*N-2:0], 1'b0};
          r_p   <= w_pnext;
          r_q   <= {r_q[2*N-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(2 * N - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        // Zero divisor: results are already loaded, spend one cycle before done.
        DZ: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_q;
  assign remainder   = r_p;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed cases, async reset mid-run,
// and every 8-bit/4-bit operand pair with random gaps and ignored start pulses.
module tb_sequential_divider;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // Reference model state: edge index of the accepted start and of the done pulse.
  int         m_start_e = -10;
  int         m_done_at = -10;
  logic [7:0] m_q = '0;
  logic [7:0] m_dvd = '0;
  logic [3:0] m_r = '0;
  logic [3:0] m_dvs = '0;
  logic       m_z = 1'b0;

  sequential_divider #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_start_e <= -10;
      m_done_at <= -10;
      m_q       <= '0;
      m_r       <= '0;
      m_z       <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (start === 1'b1 && cyc >= m_done_at) begin
        m_start_e <= cyc + 1;
        m_dvd     <= dividend;
        m_dvs     <= divisor;
        if (divisor == '0) begin
          m_done_at <= cyc + 2;
          m_q       <= 8'hFF;
          m_r       <= dividend[3:0];
          m_z       <= 1'b1;
        end else begin
          m_done_at <= cyc + 1 + 2 * N;
          m_q       <= dividend / 8'(divisor);
          m_r       <= 4'(dividend % 8'(divisor));
          m_z       <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(busy), 32'(!m_z && cyc >= m_start_e && cyc < m_done_at));
      chk("done", 32'(done), 32'(cyc == m_done_at));
      if (cyc >= m_done_at) begin
        chk("quotient", 32'(quotient), 32'(m_q));
        chk("remainder", 32'(remainder), 32'(m_r));
        chk("div_by_zero", 32'(div_by_zero), 32'(m_z));
        if (cyc == m_done_at && !m_z) begin
          chk("roundtrip", 32'(quotient) * 32'(m_dvs) + 32'(remainder), 32'(m_dvd));
          chk("rem_lt_div", 32'(remainder < m_dvs), 32'd1);
        end
      end
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input int gap,
                       input bit junk, input bit lit, input logic [7:0] eq,
                       input logic [3:0] er, input bit ez, input int elat);
    int n = 0;
    int nb = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 4'($urandom);
    while (done !== 1'b1 && n < 4 * N) begin
      if (busy === 1'b1) nb++;
      if (junk && busy === 1'b1) begin
        start = 1'b1;
        dividend = (n == 2) ? 8'd99 : 8'($urandom);
        divisor = (n == 2) ? 4'd3 : 4'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    if (lit) begin
      chk("latency", 32'(n), 32'(elat));
      chk("busy_cycles", 32'(nb), ez ? 32'd0 : 32'(elat));
      chk("lit_quotient", 32'(quotient), 32'(eq));
      chk("lit_remainder", 32'(remainder), 32'(er));
      chk("lit_dbz", 32'(div_by_zero), 32'(ez));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_quotient"}, 32'(quotient), 32'd0);
    chk({tag, "_remainder"}, 32'(remainder), 32'd0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    armed = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    do_op(8'd200, 4'd7,  1, 1'b0, 1'b1, 8'd28,  4'd0 + 4'd4, 1'b0, 8);
    do_op(8'd255, 4'd1,  1, 1'b0, 1'b1, 8'd255, 4'd0,  1'b0, 8);
    do_op(8'd5,   4'd9,  2, 1'b0, 1'b1, 8'd0,   4'd5,  1'b0, 8);
    do_op(8'd255, 4'd15, 0, 1'b0, 1'b1, 8'd17,  4'd0,  1'b0, 8);
    do_op(8'd13,  4'd0,  1, 1'b0, 1'b1, 8'hFF,  4'hD,  1'b1, 1);
    do_op(8'd200, 4'd7,  1, 1'b1, 1'b1, 8'd28,  4'd4,  1'b0, 8);
    do_op(8'd99,  4'd3,  0, 1'b0, 1'b1, 8'd33,  4'd0,  1'b0, 8);

    // Abandon an operation with an asynchronous reset in the middle of RUN.
    @(posedge clk);
    #1;
    start = 1'b1;
    dividend = 8'd200;
    divisor = 4'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    do_op(8'd144, 4'd12, 1, 1'b0, 1'b1, 8'd12, 4'd0, 1'b0, 8);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(8'(a), 4'(b), int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0),
              1'b0, 8'd0, 4'd0, 1'b0, 0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
